// File: rtl/ad9958_pkg.sv
// Shared AD9958 definitions: register map, sequencer state encoding and the
// register-length lookup used to size each write frame.
package ad9958_pkg;

  localparam logic [4:0] ADDR_CSR   = 5'h00;
  localparam logic [4:0] ADDR_FR1   = 5'h01;
  localparam logic [4:0] ADDR_FR2   = 5'h02;
  localparam logic [4:0] ADDR_CFR   = 5'h03;
  localparam logic [4:0] ADDR_CFTW0 = 5'h04;
  localparam logic [4:0] ADDR_CPOW0 = 5'h05;
  localparam logic [4:0] ADDR_ACR   = 5'h06;
  localparam logic [4:0] ADDR_LSRR  = 5'h07;
  localparam logic [4:0] ADDR_RDW   = 5'h08;
  localparam logic [4:0] ADDR_FDW   = 5'h09;
  localparam logic [4:0] ADDR_CW1   = 5'h0A;
  localparam logic [4:0] ADDR_CW2   = 5'h0B;
  localparam logic [4:0] ADDR_CW3   = 5'h0C;
  localparam logic [4:0] ADDR_CW4   = 5'h0D;
  localparam logic [4:0] ADDR_CW5   = 5'h0E;
  localparam logic [4:0] ADDR_CW6   = 5'h0F;
  localparam logic [4:0] ADDR_CW7   = 5'h10;
  localparam logic [4:0] ADDR_CW8   = 5'h11;
  localparam logic [4:0] ADDR_CW9   = 5'h12;
  localparam logic [4:0] ADDR_CW10  = 5'h13;
  localparam logic [4:0] ADDR_CW11  = 5'h14;
  localparam logic [4:0] ADDR_CW12  = 5'h15;
  localparam logic [4:0] ADDR_CW13  = 5'h16;
  localparam logic [4:0] ADDR_CW14  = 5'h17;
  localparam logic [4:0] ADDR_CW15  = 5'h18;
  localparam logic [4:0] ADDR_MAX   = 5'h18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
`ifdef AD9958_IO_UPDATE_EN
    ST_IO_UPD,
`endif
    ST_DONE
  } state_e;

  // Register length in bytes; 0 marks an address outside the register map.
  function automatic logic [2:0] reg_len(input logic [4:0] addr);
    case (addr)
      ADDR_CSR:                       reg_len = 3'd1;
      ADDR_FR2, ADDR_CPOW0, ADDR_LSRR: reg_len = 3'd2;
      ADDR_FR1, ADDR_CFR, ADDR_ACR:   reg_len = 3'd3;
      default:                        reg_len = (addr <= ADDR_MAX) ? 3'd4 : 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ad9958_frame_builder.sv
// Combinational pack mux: selects the 4-bit pack at pack_idx from the frame
// {instruction byte, data[8*len-1:0]}, bytes MSB first, high nibble first.
module ad9958_frame_builder (
  input  logic [4:0]  addr,
  input  logic [31:0] data,
  input  logic [2:0]  len,
  input  logic [3:0]  pack_idx,
  output logic [3:0]  nibble_data
);

  logic [5:0]  pad_bits;
  logic [31:0] data_aligned;
  logic [39:0] frame;
  logic [39:0] frame_shifted;

  always_comb begin
    // Left-align the used data bytes so the frame always starts at bit 39.
    pad_bits      = {3'd4 - len, 3'b000};
    data_aligned  = data << pad_bits;
    frame         = {3'b000, addr, data_aligned};
    frame_shifted = frame << {pack_idx, 2'b00};
    nibble_data   = frame_shifted[39:36];
  end

endmodule

// File: rtl/ad9958_reg_writer.sv
// AD9958 register-write sequencer: latches one request, streams the frame as
// nibbles, then optionally pulses IO_UPDATE (macro AD9958_IO_UPDATE_EN).
module ad9958_reg_writer
  import ad9958_pkg::*;
#(
  parameter int unsigned CS_SETUP_CYCLES  = 2,
  parameter int unsigned IO_UPDATE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_data,
  output logic [3:0]  nibble_data,
  output logic        nibble_valid,
  input  logic        nibble_ready,
  output logic [3:0]  frame_packs,
  output logic        frame_active,
  output logic        io_update,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] CS_LAST = 4'(CS_SETUP_CYCLES - 1);
`ifdef AD9958_IO_UPDATE_EN
  localparam logic [3:0] IO_LAST = 4'(IO_UPDATE_CYCLES - 1);
`endif

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  pack_idx_q, pack_idx_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  len_q, len_d;
  logic [3:0]  frame_packs_q, frame_packs_d;
  logic        req_ready_q, req_ready_d;
  logic        frame_active_q, frame_active_d;
  logic        nibble_valid_q, nibble_valid_d;
  logic        io_update_q, io_update_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pack_idx_d    = pack_idx_q;
    addr_d        = addr_q;
    data_d        = data_q;
    len_d         = len_q;
    frame_packs_d = frame_packs_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d = req_addr;
          data_d = req_data;
          len_d  = reg_len(req_addr);
          if (len_d != 3'd0) begin
            frame_packs_d = 4'd2 + {len_d, 1'b0};
            state_d       = ST_CS_SETUP;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == CS_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SHIFT: begin
        if (nibble_ready) begin
          if (pack_idx_q == frame_packs_q - 4'd1) begin
            pack_idx_d = '0;
            state_d    = ST_CS_HOLD;
          end else begin
            pack_idx_d = pack_idx_q + 4'd1;
          end
        end
      end
`ifdef AD9958_IO_UPDATE_EN
      ST_CS_HOLD: state_d = ST_IO_UPD;
      ST_IO_UPD: begin
        if (cnt_q == IO_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`else
      ST_CS_HOLD: state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so each lines up with it.
    req_ready_d    = (state_d == ST_IDLE);
    frame_active_d = (state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) ||
                     (state_d == ST_CS_HOLD);
    nibble_valid_d = (state_d == ST_SHIFT);
    done_d         = (state_d == ST_DONE);
    err_d          = (state_d == ST_ERR);
`ifdef AD9958_IO_UPDATE_EN
    io_update_d    = (state_d == ST_IO_UPD);
`else
    io_update_d    = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pack_idx_q     <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      len_q          <= '0;
      frame_packs_q  <= '0;
      req_ready_q    <= 1'b0;
      frame_active_q <= 1'b0;
      nibble_valid_q <= 1'b0;
      io_update_q    <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pack_idx_q     <= pack_idx_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      len_q          <= len_d;
      frame_packs_q  <= frame_packs_d;
      req_ready_q    <= req_ready_d;
      frame_active_q <= frame_active_d;
      nibble_valid_q <= nibble_valid_d;
      io_update_q    <= io_update_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  ad9958_frame_builder u_frame_builder (
    .addr        (addr_q),
    .data        (data_q),
    .len         (len_q),
    .pack_idx    (pack_idx_q),
    .nibble_data (nibble_data)
  );

  assign req_ready    = req_ready_q;
  assign nibble_valid = nibble_valid_q;
  assign frame_packs  = frame_packs_q;
  assign frame_active = frame_active_q;
  assign io_update    = io_update_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ad9958_reg_writer.sv
// Scoreboard bench for ad9958_reg_writer: expected frames are queued at issue
// time and checked by an independent monitor on the falling clock edge.
module tb_ad9958_reg_writer;

  localparam int CSC = 2;
  localparam int IOC = 4;
`ifdef AD9958_IO_UPDATE_EN
  localparam int IO_EXP = IOC;
`else
  localparam int IO_EXP = 0;
`endif

  logic        clock, reset_n;
  logic        req_valid, req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  nibble_data;
  logic        nibble_valid, nibble_ready;
  logic [3:0]  frame_packs;
  logic        frame_active, io_update, done, err;

  ad9958_reg_writer #(.CS_SETUP_CYCLES(CSC), .IO_UPDATE_CYCLES(IOC)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .nibble_data(nibble_data), .nibble_valid(nibble_valid), .nibble_ready(nibble_ready),
    .frame_packs(frame_packs), .frame_active(frame_active),
    .io_update(io_update), .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         is_err;
    int         packs;
    int         n;
    int         lat;
    int         acc;
    logic [3:0] nib [10];
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ready_mode = 0;
  int   stall_at = 0;
  int   stall_left = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int model_len(input int a);
    if (a == 0) return 1;
    if (a == 1 || a == 3 || a == 6) return 3;
    if (a == 2 || a == 5 || a == 7) return 2;
    if (a <= 24) return 4;
    return 0;
  endfunction

  function automatic exp_t build_exp(input int a, input logic [31:0] d, input bit timed, input int acc);
    exp_t e;
    int   len;
    int   b;
    len = model_len(a);
    for (int i = 0; i < 10; i++) e.nib[i] = 4'h0;
    e.is_err = (len == 0);
    e.packs  = 2 + 2 * len;
    e.acc    = acc;
    e.n      = 0;
    if (!e.is_err) begin
      e.nib[0] = 4'(a / 16);
      e.nib[1] = 4'(a % 16);
      e.n = 2;
      for (int k = len - 1; k >= 0; k--) begin
        b = int'((d >> (8 * k)) & 32'hFF);
        e.nib[e.n]     = 4'(b / 16);
        e.nib[e.n + 1] = 4'(b % 16);
        e.n += 2;
      end
    end
    if (!timed)         e.lat = -1;
    else if (e.is_err)  e.lat = 0;
    else                e.lat = CSC + 2 * len + 3 + IO_EXP;
    return e;
  endfunction

  // Monitor / scoreboard
  int nib_cnt = 0;
  int io_cnt  = 0;
  bit fa_seen = 0;
  bit prev_fa = 0;
  bit ready_pending = 0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      nib_cnt = 0; io_cnt = 0; fa_seen = 0; prev_fa = 0; ready_pending = 0;
    end else begin
      if (ready_pending) begin
        chk("ready_after_end", req_ready, 1);
        ready_pending = 0;
      end
      if (frame_active) begin
        fa_seen = 1;
        if (exp_q.size() > 0) chk("frame_packs", frame_packs, exp_q[0].packs);
        else chk("frame_without_request", 1, 0);
      end
      if (io_update) begin
        if (io_cnt == 0) chk("io_starts_after_frame", prev_fa, 1);
        chk("io_frame_overlap", frame_active, 0);
        io_cnt++;
      end
      if (nibble_valid) begin
        if (exp_q.size() == 0) chk("nibble_without_request", 1, 0);
        else if (nib_cnt >= exp_q[0].n) chk("nibble_overrun", nib_cnt, exp_q[0].n - 1);
        else chk("nibble_data", nibble_data, exp_q[0].nib[nib_cnt]);
        if (nibble_ready) nib_cnt++;
      end
      if (done || err) begin
        chk("done_err_exclusive", done && err, 0);
        if (exp_q.size() == 0) begin
          chk("end_without_request", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("end_is_err", err, e.is_err);
          if (e.is_err) begin
            chk("err_frame_active", fa_seen, 0);
          end else begin
            chk("nibble_count", nib_cnt, e.n);
            chk("io_update_cycles", io_cnt, IO_EXP);
          end
          if (e.lat >= 0) chk("latency", cyc - e.acc, e.lat);
        end
        nib_cnt = 0; io_cnt = 0; fa_seen = 0; ready_pending = 1;
      end
      prev_fa = frame_active;
    end
  end

  // Serializer model: ready pattern chosen by the current mode.
  initial begin
    nibble_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: nibble_ready = 1'b1;
        1: nibble_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (nibble_valid && nib_cnt == stall_at && stall_left > 0) begin
            nibble_ready = 1'b0;
            stall_left--;
          end else begin
            nibble_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic send(input int a, input logic [31:0] d, input int mode, input bit hold_extra);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clock);
    while (!req_ready && w < 1000) begin
      @(negedge clock);
      w++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", req_ready, 1);
      return;
    end
    ready_mode = mode;
    req_valid  = 1'b1;
    req_addr   = 5'(a);
    req_data   = d;
    e = build_exp(a, d, mode == 0, cyc + 1);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (hold_extra && !e.is_err) begin
      req_addr = 5'($urandom_range(0, 31));
      req_data = $urandom;
      repeat (3) @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clock);
      w++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_nibble_valid"}, nibble_valid, 0);
    chk({tag, "_nibble_data"}, nibble_data, 0);
    chk({tag, "_frame_packs"}, frame_packs, 0);
    chk({tag, "_frame_active"}, frame_active, 0);
    chk({tag, "_io_update"}, io_update, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int w;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    #1;
    check_reset_outputs("reset");
    #22;
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_release", req_ready, 1);

    send(5'h00, 32'h0000_00F0, 0, 0);
    send(5'h04, 32'h1234_5678, 0, 1);
    send(5'h1F, 32'hDEAD_BEEF, 0, 0);
    stall_at = 4; stall_left = 5;
    send(5'h01, 32'h00AB_CDEF, 2, 0);
    send(5'h05, 32'h0000_3FFF, 0, 0);
    send(5'h18, 32'hCAFE_F00D, 0, 0);
    wait_drain();

    // Reset in the middle of a CW1 frame abandons it.
    send(5'h0A, 32'h89AB_CDEF, 0, 0);
    w = 0;
    while (nib_cnt != 5 && w < 200) begin
      @(negedge clock);
      #1;
      w++;
    end
    chk("reach_pack5_timeout", nib_cnt, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midframe");
    exp_q.delete();
    @(negedge clock);
    chk("held_reset_frame_active", frame_active, 0);
    #3;
    reset_n = 1'b1;
    send(5'h00, 32'h0000_005A, 0, 0);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
